seq_sub_12b: RTL and testbench

- Multi-cycle 12-bit subtractor: D = A − B, computed as A + ~B + 1.
- Processes one 3-bit slice per clock, LSB slice first, with the carry registered between slices.
- Complements the team's 3-bit carry-lookahead adder slices: it is the subtract direction, built as a small sequential datapath with a ready/valid handshake on both sides.
- Used where area matters more than latency, e.g. compare/decrement paths in the 12-bit datapath.

---
 rtl/seq_sub_12b.sv | 131 +++++++++++++
 tb/tb_seq_sub_12b.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_sub_12b.sv
// Sequential 12-bit subtractor: D = A + ~B + 1, one SLICE-bit slice per clock, LSB first,
// with a registered carry between slices and ready/valid handshakes on both sides.
module seq_sub_12b #(
  parameter int  SLICE   = 3,
  parameter int  NSLICES = 4,
  localparam int W       = SLICE * NSLICES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         borrow,
  output logic         ovf
);

  localparam int CNT_W = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     aR_q, aR_d;
  logic [W-1:0]     nbR_q, nbR_d;
  logic [W-1:0]     diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             bMsb_q, bMsb_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] aSlice;
  logic [SLICE-1:0] nbSlice;
  logic [SLICE:0]   sliceSum;

  // One slice of A + ~B + carry; the top bit is the carry into the next slice.
  always_comb begin
    aSlice   = aR_q[int'(cnt_q) * SLICE +: SLICE];
    nbSlice  = nbR_q[int'(cnt_q) * SLICE +: SLICE];
    sliceSum = {1'b0, aSlice} + {1'b0, nbSlice} + {{SLICE{1'b0}}, carry_q};
  end

  always_comb begin
    state_d   = state_q;
    aR_d      = aR_q;
    nbR_d     = nbR_q;
    diff_d    = diff_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    bMsb_d    = bMsb_q;
    borrow_d  = borrow_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          aR_d    = a;
          nbR_d   = ~b;
          bMsb_d  = b[W-1];
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        diff_d[int'(cnt_q) * SLICE +: SLICE] = sliceSum[SLICE-1:0];
        carry_d = sliceSum[SLICE];
        cnt_d   = cnt_q + 1'b1;
        // Flags use the final carry and the MSB of the slice being written this edge.
        if (cnt_q == LAST_CNT) begin
          cnt_d    = '0;
          borrow_d = ~sliceSum[SLICE];
          ovf_d    = (aR_q[W-1] != bMsb_q) && (sliceSum[SLICE-1] != aR_q[W-1]);
          state_d  = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      aR_q     <= '0;
      nbR_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b1;
      bMsb_q   <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      aR_q     <= aR_d;
      nbR_q    <= nbR_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      bMsb_q   <= bMsb_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_seq_sub_12b.sv
// Self-checking bench for seq_sub_12b: directed and random operations against an
// arithmetic reference model, with backpressure, ignored inputs and mid-operation reset.
module tb_seq_sub_12b;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a;
  logic [11:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] diff;
  logic        borrow;
  logic        ovf;

  int nChecks = 0;
  int nFails  = 0;

  seq_sub_12b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: plain modular, unsigned and signed arithmetic on the operands.
  function automatic void modelSub(input logic [11:0] av, input logic [11:0] bv,
                                   output logic [11:0] d, output logic br, output logic ov);
    int sa;
    int sb;
    int sd;
    d  = av - bv;
    br = (av < bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    sd = sa - sb;
    ov = (sd > 2047) || (sd < -2048);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_diff", 32'(diff), 32'd0);
    checkOutput("rst_borrow", 32'(borrow), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
  endtask

  // Waits (bounded) for in_ready, presents operands for exactly one edge; returns one cycle later.
  task automatic applyStimulus(input logic [11:0] av, input logic [11:0] bv);
    int waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic doOp(input logic [11:0] av, input logic [11:0] bv,
                      input int holdCycles, input bit garbage);
    logic [11:0] eDiff;
    logic        eBorrow;
    logic        eOvf;
    modelSub(av, bv, eDiff, eBorrow, eOvf);
    out_ready = (holdCycles == 0);
    applyStimulus(av, bv);
    for (int i = 0; i < 4; i++) begin
      checkOutput("calc_in_ready", 32'(in_ready), 32'd0);
      checkOutput("calc_out_valid", 32'(out_valid), 32'd0);
      if (garbage) begin
        in_valid = 1'($urandom);
        a        = 12'($urandom);
        b        = 12'($urandom);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("done_out_valid", 32'(out_valid), 32'd1);
    checkOutput("done_in_ready", 32'(in_ready), 32'd0);
    checkOutput("diff", 32'(diff), 32'(eDiff));
    checkOutput("borrow", 32'(borrow), 32'(eBorrow));
    checkOutput("ovf", 32'(ovf), 32'(eOvf));
    for (int h = 0; h < holdCycles; h++) begin
      if (garbage) begin
        in_valid = 1'($urandom);
        a        = 12'($urandom);
        b        = 12'($urandom);
      end
      @(negedge clk);
      checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_diff", 32'(diff), 32'(eDiff));
      checkOutput("hold_borrow", 32'(borrow), 32'(eBorrow));
      checkOutput("hold_ovf", 32'(ovf), 32'(eOvf));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("ret_in_ready", 32'(in_ready), 32'd1);
    checkOutput("ret_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    checkReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed operations");
    doOp(12'h064, 12'h025, 0, 1'b0);
    doOp(12'h005, 12'h009, 0, 1'b0);
    doOp(12'h800, 12'h001, 0, 1'b0);
    doOp(12'h000, 12'h800, 0, 1'b0);
    doOp(12'hABC, 12'hABC, 0, 1'b0);

    $display("[TB] backpressure with ignored inputs");
    doOp(12'h3A7, 12'h9C2, 5, 1'b1);

    $display("[TB] reset mid-operation");
    out_ready = 1'b1;
    applyStimulus(12'h123, 12'h456);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkReset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    end
    doOp(12'h456, 12'h123, 0, 1'b0);

    $display("[TB] random operations");
    for (int n = 0; n < 20; n++) begin
      doOp(12'($urandom), 12'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
